tdc_depth_avg: RTL and testbench

//  Consumes the per-shot TDC result stream (1..3 tof/intensity beats ending in last) on the 250 MHz logic clock.
//  Per shot, keeps the strongest return and counts a hit or a miss. Accumulates 2**AVG_LOG2 shots.

---
 rtl/tdc_depth_avg_if.sv | 30 +++
 rtl/tdc_depth_avg.sv | 179 +++++++++++++++++
 tb/tb_tdc_depth_avg.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tdc_depth_avg_if.sv
// Stream/result bundle for tdc_depth_avg: TDC beat stream in, averaged result out.
// The slave modport is the averager's view, master is the upstream/downstream side.
interface tdc_depth_avg_if #(
    parameter int DW       = 10,
    parameter int IW       = 5,
    parameter int AVG_LOG2 = 3
);
    logic                  s_tvalid;
    logic                  s_tready;
    logic [DW-1:0]         s_tdata;
    logic [IW-1:0]         s_tint;
    logic                  s_tlast;
    logic                  shot_done;
    logic                  m_valid;
    logic                  m_ready;
    logic [DW-1:0]         m_depth;
    logic [IW+AVG_LOG2-1:0] m_int_sum;
    logic [AVG_LOG2:0]     m_hits;
    logic                  m_overrun;

    modport master (
        output s_tvalid, s_tdata, s_tint, s_tlast, shot_done, m_ready,
        input  s_tready, m_valid, m_depth, m_int_sum, m_hits, m_overrun
    );

    modport slave (
        input  s_tvalid, s_tdata, s_tint, s_tlast, shot_done, m_ready,
        output s_tready, m_valid, m_depth, m_int_sum, m_hits, m_overrun
    );
endinterface

// File: rtl/tdc_depth_avg.sv
// Per-shot strongest-return selection and 2**AVG_LOG2-shot depth averaging.
// ACC collects shots, DIV runs a bit-serial restoring divide, OUT holds the result
// until the consumer takes it.
module tdc_depth_avg #(
    parameter int DW       = 10,
    parameter int IW       = 5,
    parameter int AVG_LOG2 = 3,
    parameter int MIN_INT  = 1
) (
    input  logic           clk,
    input  logic           rst,
    tdc_depth_avg_if.slave bus
);
    localparam int AW = DW + AVG_LOG2;          // depth accumulator / dividend width
    localparam int SW = IW + AVG_LOG2;          // intensity sum width
    localparam int HW = AVG_LOG2 + 1;           // hit / shot counter width
    localparam int RW = HW + 1;                 // shifted partial remainder width
    localparam int CW = $clog2(AW);
    localparam logic [HW-1:0] SHOTS_FULL = HW'(1 << AVG_LOG2);
    localparam logic [CW-1:0] DIV_LAST   = CW'(AW - 1);
    localparam logic [IW-1:0] MIN_I      = IW'(MIN_INT);

    typedef enum logic [1:0] {ST_ACC, ST_DIV, ST_OUT} state_t;
    state_t state_reg, state_next;

    logic [DW-1:0] best_d_reg;
    logic [IW-1:0] best_i_reg;
    logic          got_burst_reg, armed_reg, ovr_reg;
    logic [AW-1:0] acc_d_reg;
    logic [SW-1:0] acc_i_reg;
    logic [HW-1:0] hits_reg, shots_reg;
    logic [AW-1:0] quo_reg;
    logic [HW-1:0] rem_reg, div_reg;
    logic [SW-1:0] res_i_reg;
    logic [CW-1:0] cnt_reg;
    logic [DW-1:0] m_depth_reg;
    logic [SW-1:0] m_int_sum_reg;
    logic [HW-1:0] m_hits_reg;
    logic          m_overrun_reg;

    logic          beat_acc, take_beat, burst_commit, miss_commit, commit, is_hit;
    logic          full, div_done, out_entry, rem_ge;
    logic [DW-1:0] cand_d;
    logic [IW-1:0] cand_i;
    logic [AW-1:0] acc_d_next;
    logic [SW-1:0] acc_i_next;
    logic [HW-1:0] hits_next, shots_next;
    logic [RW-1:0] rem_sh;

    // Commit decision: a window commits at most once, either its first burst or a miss
    always_comb begin
        beat_acc     = bus.s_tvalid && (state_reg == ST_ACC);
        take_beat    = beat_acc && (bus.s_tint >= MIN_I) && (bus.s_tint > best_i_reg);
        cand_d       = take_beat ? bus.s_tdata : best_d_reg;
        cand_i       = take_beat ? bus.s_tint  : best_i_reg;
        burst_commit = beat_acc && bus.s_tlast && !got_burst_reg;
        // a last beat in the same cycle as shot_done already closes the window
        miss_commit  = (state_reg == ST_ACC) && bus.shot_done && armed_reg
                       && !got_burst_reg && !burst_commit;
        commit       = burst_commit || miss_commit;
        is_hit       = burst_commit && (cand_i >= MIN_I);
        acc_d_next   = acc_d_reg + (is_hit ? AW'(cand_d) : AW'(0));
        acc_i_next   = acc_i_reg + (is_hit ? SW'(cand_i) : SW'(0));
        hits_next    = hits_reg + (is_hit ? HW'(1) : HW'(0));
        shots_next   = shots_reg + (commit ? HW'(1) : HW'(0));
        full         = commit && (shots_next == SHOTS_FULL);
        rem_sh       = {rem_reg, quo_reg[AW-1]};
        rem_ge       = rem_sh >= RW'(div_reg);
        div_done     = (state_reg == ST_DIV) && (cnt_reg == DIV_LAST);
        out_entry    = (full && (hits_next == '0)) || div_done;
    end

    // Next-state selection for the ACC -> DIV -> OUT loop
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_ACC:  if (full) state_next = (hits_next != '0) ? ST_DIV : ST_OUT;
            ST_DIV:  if (cnt_reg == DIV_LAST) state_next = ST_OUT;
            ST_OUT:  if (bus.m_ready) state_next = ST_ACC;
            default: state_next = ST_ACC;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_reg <= ST_ACC;
        else     state_reg <= state_next;
    end

    // Best tracking, window flags, accumulation, serial divide and result capture
    always_ff @(posedge clk) begin
        if (rst) begin
            best_d_reg    <= '0;
            best_i_reg    <= '0;
            got_burst_reg <= 1'b0;
            armed_reg     <= 1'b0;
            ovr_reg       <= 1'b0;
            acc_d_reg     <= '0;
            acc_i_reg     <= '0;
            hits_reg      <= '0;
            shots_reg     <= '0;
            quo_reg       <= '0;
            rem_reg       <= '0;
            div_reg       <= '0;
            res_i_reg     <= '0;
            cnt_reg       <= '0;
            m_depth_reg   <= '0;
            m_int_sum_reg <= '0;
            m_hits_reg    <= '0;
            m_overrun_reg <= 1'b0;
        end else begin
            if (beat_acc) begin
                if (bus.s_tlast) begin
                    best_d_reg <= '0;
                    best_i_reg <= '0;
                end else begin
                    best_d_reg <= cand_d;
                    best_i_reg <= cand_i;
                end
            end

            if (bus.shot_done) begin
                got_burst_reg <= 1'b0;
                if (state_reg == ST_ACC) armed_reg <= 1'b1;
            end else if (burst_commit) begin
                got_burst_reg <= 1'b1;
            end

            // drops seen while busy are reported on the next result to be presented
            if (out_entry)
                ovr_reg <= 1'b0;
            else if (bus.shot_done && (state_reg != ST_ACC))
                ovr_reg <= 1'b1;

            if (full) begin
                acc_d_reg <= '0;
                acc_i_reg <= '0;
                hits_reg  <= '0;
                shots_reg <= '0;
                quo_reg   <= acc_d_next;
                rem_reg   <= '0;
                div_reg   <= hits_next;
                res_i_reg <= acc_i_next;
                cnt_reg   <= '0;
            end else if (commit) begin
                acc_d_reg <= acc_d_next;
                acc_i_reg <= acc_i_next;
                hits_reg  <= hits_next;
                shots_reg <= shots_next;
            end

            // one restoring-division quotient bit per cycle, MSB first
            if (state_reg == ST_DIV) begin
                quo_reg <= {quo_reg[AW-2:0], rem_ge};
                rem_reg <= rem_ge ? HW'(rem_sh - RW'(div_reg)) : rem_sh[HW-1:0];
                cnt_reg <= cnt_reg + CW'(1);
            end

            if (full && (hits_next == '0)) begin
                m_depth_reg   <= '0;
                m_int_sum_reg <= '0;
                m_hits_reg    <= '0;
                m_overrun_reg <= ovr_reg;
            end else if (div_done) begin
                m_depth_reg   <= {quo_reg[DW-2:0], rem_ge};
                m_int_sum_reg <= res_i_reg;
                m_hits_reg    <= div_reg;
                m_overrun_reg <= ovr_reg | bus.shot_done;
            end
        end
    end

    assign bus.s_tready  = (state_reg == ST_ACC);
    assign bus.m_valid   = (state_reg == ST_OUT);
    assign bus.m_depth   = m_depth_reg;
    assign bus.m_int_sum = m_int_sum_reg;
    assign bus.m_hits    = m_hits_reg;
    assign bus.m_overrun = m_overrun_reg;
endmodule

// File: tb/tb_tdc_depth_avg.sv
// Bench for tdc_depth_avg: table of shot patterns with hand-computed results,
// hand sequences for reset/backpressure/tie/discard, and random shots checked
// against a shot-level arithmetic model.
module tb_tdc_depth_avg;
    localparam int DW = 10;
    localparam int IW = 5;
    localparam int AL = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tdc_depth_avg_if #(.DW(DW), .IW(IW), .AVG_LOG2(AL)) bus ();

    tdc_depth_avg #(.DW(DW), .IW(IW), .AVG_LOG2(AL), .MIN_INT(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int n_hit;
        int d0;
        int dstep;
        int iv;
        bit triple;
        int n_zero;
        int n_empty;
        int exp_d;
        int exp_i;
        int exp_h;
    } vec_t;

    vec_t vecs[8];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic beat(input int d, input int i, input bit last, input bit sd);
        int n = 0;
        while (!bus.s_tready && n < 100) begin
            tick();
            n++;
        end
        if (!bus.s_tready) check("s_tready wait", bus.s_tready, 1);
        bus.s_tvalid  = 1'b1;
        bus.s_tdata   = DW'(d);
        bus.s_tint    = IW'(i);
        bus.s_tlast   = last;
        bus.shot_done = sd;
        tick();
        bus.s_tvalid  = 1'b0;
        bus.s_tlast   = 1'b0;
        bus.shot_done = 1'b0;
    endtask

    task automatic pulse();
        bus.shot_done = 1'b1;
        tick();
        bus.shot_done = 1'b0;
    endtask

    // Called right after the final commit edge: checks latency, values, optional stall, handshake
    task automatic finish_result(input string tag, input int ed, input int ei, input int eh,
                                 input int eo, input int stall);
        int n = 0;
        logic [DW-1:0] cd;
        logic [IW+AL-1:0] ci;
        logic [AL:0] ch;
        logic co;
        bit stable = 1'b1;
        bit rdy_low = 1'b1;
        if (stall > 0) bus.m_ready = 1'b0;
        while (!bus.m_valid && n < 100) begin
            tick();
            n++;
        end
        check({tag, " latency"}, n + 1, (eh > 0) ? 14 : 1);
        check({tag, " m_depth"}, bus.m_depth, ed);
        check({tag, " m_int_sum"}, bus.m_int_sum, ei);
        check({tag, " m_hits"}, bus.m_hits, eh);
        check({tag, " m_overrun"}, bus.m_overrun, eo);
        $display("result %s: depth=%0d int_sum=%0d hits=%0d overrun=%0d latency=%0d",
                 tag, bus.m_depth, bus.m_int_sum, bus.m_hits, bus.m_overrun, n + 1);
        if (stall > 0) begin
            cd = bus.m_depth;
            ci = bus.m_int_sum;
            ch = bus.m_hits;
            co = bus.m_overrun;
            for (int k = 0; k < stall; k++) begin
                bus.shot_done = (k == 5 || k == 12);
                tick();
                bus.shot_done = 1'b0;
                if (!bus.m_valid || bus.m_depth != cd || bus.m_int_sum != ci ||
                    bus.m_hits != ch || bus.m_overrun != co) stable = 1'b0;
                if (bus.s_tready) rdy_low = 1'b0;
            end
            check({tag, " held under stall"}, stable, 1);
            check({tag, " s_tready low in OUT"}, rdy_low, 1);
            bus.m_ready = 1'b1;
        end
        tick();
        check({tag, " m_valid after handshake"}, bus.m_valid, 0);
    endtask

    task automatic run_vec(input string tag, input vec_t v, input int eo, input int stall);
        int total = v.n_hit + v.n_zero + v.n_empty;
        int s = 0;
        int d;
        for (int k = 0; k < v.n_hit; k++) begin
            d = v.d0 + k * v.dstep;
            if (v.triple) begin
                beat(d - 10, 3, 1'b0, 1'b0);
                beat(d, v.iv, 1'b0, 1'b0);
                beat(d + 10, v.iv, 1'b1, 1'b1);
            end else begin
                beat(d, v.iv, 1'b1, 1'b1);
            end
            if (s != total - 1) idle(1);
            s++;
        end
        for (int k = 0; k < v.n_zero; k++) begin
            beat(500, 0, 1'b1, 1'b1);
            if (s != total - 1) idle(1);
            s++;
        end
        for (int k = 0; k < v.n_empty; k++) begin
            pulse();
            if (s != total - 1) idle(1);
            s++;
        end
        finish_result(tag, v.exp_d, v.exp_i, v.exp_h, eo, stall);
    endtask

    // Random shots; expectation from first-strongest-return-per-window and integer averaging
    task automatic run_random(input int r);
        int sum_d = 0;
        int sum_i = 0;
        int hits  = 0;
        int nb, bd, bi, d, i;
        bit same, fin;
        for (int s = 0; s < 8; s++) begin
            fin = (s == 7);
            if ($urandom_range(0, 3) == 0) begin
                pulse();
            end else begin
                nb = $urandom_range(1, 3);
                bd = 0;
                bi = 0;
                same = fin || ($urandom_range(0, 1) == 1);
                for (int b = 0; b < nb; b++) begin
                    d = $urandom_range(0, 1023);
                    i = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 31);
                    if (i >= 1 && i > bi) begin
                        bi = i;
                        bd = d;
                    end
                    beat(d, i, b == nb - 1, same && (b == nb - 1));
                    if (b < nb - 1 && $urandom_range(0, 1) == 1) idle(1);
                end
                if (bi > 0) begin
                    hits++;
                    sum_d += bd;
                    sum_i += bi;
                end
                if (!same) begin
                    idle($urandom_range(0, 2));
                    if ($urandom_range(0, 1) == 1)
                        beat($urandom_range(0, 1023), $urandom_range(1, 31), 1'b1, 1'b0);
                    pulse();
                end
            end
            if (!fin) idle($urandom_range(0, 2));
        end
        finish_result($sformatf("rnd%0d", r), (hits > 0) ? sum_d / hits : 0, sum_i, hits, 0,
                      $urandom_range(0, 4));
    endtask

    task automatic run_tie_discard();
        for (int k = 0; k < 7; k++) begin
            beat(300, 5, 1'b0, 1'b0);
            beat(400, 5, 1'b1, 1'b0);
            idle(1);
            beat(900, 20, 1'b1, 1'b0);
            pulse();
            idle(1);
        end
        beat(300, 5, 1'b0, 1'b0);
        beat(400, 5, 1'b1, 1'b1);
        finish_result("tie_discard", 300, 40, 8, 0, 0);
    endtask

    task automatic run_reset_in_div();
        bit seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            beat(5, 1, 1'b1, 1'b1);
            if (k != 7) idle(1);
        end
        idle(4);
        check("div s_tready", bus.s_tready, 0);
        check("div m_valid", bus.m_valid, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst-div s_tready", bus.s_tready, 1);
        check("rst-div m_valid", bus.m_valid, 0);
        check("rst-div m_depth", bus.m_depth, 0);
        check("rst-div m_hits", bus.m_hits, 0);
        for (int k = 0; k < 20; k++) begin
            tick();
            if (bus.m_valid) seen = 1'b1;
        end
        check("rst-div no m_valid", seen, 0);
        $display("reset during DIV: s_tready=%0d m_valid=%0d", bus.s_tready, bus.m_valid);
    endtask

    initial begin
        //          hit  d0   st  iv  tri zero empty exp_d exp_i exp_h
        vecs[0] = '{8,   60,  0,  7,  1,  0,   0,    60,   56,   8};
        vecs[1] = '{8,   10,  1,  2,  0,  0,   0,    13,   16,   8};
        vecs[2] = '{5,   100, 1,  4,  0,  0,   3,    102,  20,   5};
        vecs[3] = '{6,   200, 3,  9,  0,  2,   0,    207,  54,   6};
        vecs[4] = '{8,   1023,0,  31, 0,  0,   0,    1023, 248,  8};
        vecs[5] = '{1,   777, 0,  1,  0,  0,   7,    777,  1,    1};
        vecs[6] = '{0,   0,   0,  0,  0,  8,   0,    0,    0,    0};
        vecs[7] = '{3,   900, 50, 10, 0,  2,   3,    950,  30,   3};

        rst           = 1'b1;
        bus.s_tvalid  = 1'b0;
        bus.s_tdata   = '0;
        bus.s_tint    = '0;
        bus.s_tlast   = 1'b0;
        bus.shot_done = 1'b0;
        bus.m_ready   = 1'b1;
        idle(2);
        rst = 1'b0;
        check("reset s_tready", bus.s_tready, 1);
        check("reset m_valid", bus.m_valid, 0);
        check("reset m_depth", bus.m_depth, 0);
        check("reset m_int_sum", bus.m_int_sum, 0);
        check("reset m_hits", bus.m_hits, 0);
        check("reset m_overrun", bus.m_overrun, 0);
        $display("reset: s_tready=%0d m_valid=%0d", bus.s_tready, bus.m_valid);

        pulse();     // first window end only arms
        idle(1);

        for (int k = 0; k < 8; k++) begin
            run_vec($sformatf("vec%0d", k), vecs[k], 0, 0);
            idle(1);
        end

        run_vec("stall", vecs[1], 0, 20);
        idle(1);
        run_vec("after_stall", vecs[0], 1, 0);
        idle(1);
        run_vec("ovr_cleared", vecs[2], 0, 0);
        idle(1);

        run_tie_discard();
        idle(1);

        run_reset_in_div();
        for (int k = 0; k < 9; k++) begin
            pulse();
            if (k != 8) idle(1);
        end
        finish_result("all_empty", 0, 0, 0, 0, 0);
        idle(1);

        for (int r = 0; r < 6; r++) begin
            run_random(r);
            idle($urandom_range(0, 2));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
